// File: rtl/bus_arbiter_pkg.sv
// Shared types for the common-bus arbiter: bus source encoding and FSM state.
package bus_arbiter_pkg;

  // Bus multiplexer source select. 4 bits wide so that unused codes can
  // travel through the arbiter unchanged; the multiplexer maps them to zero.
  typedef enum logic [3:0] {
    idle_bus = 4'd0,
    AC_bus   = 4'd1,
    DR_bus   = 4'd2,
    PC_bus   = 4'd3,
    AR_bus   = 4'd4,
    IR_bus   = 4'd5,
    MEM_bus  = 4'd6,
    TR_bus   = 4'd7
  } bus_in_sel_t;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// Requester/arbiter bundle. Requesters drive through the master modport,
// the arbiter sees the slave modport.
interface bus_arbiter_if
  import bus_arbiter_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int DEST_W = 9
);
  logic [N_REQ-1:0]             req;
  logic [N_REQ-1:0]             lock;
  bus_in_sel_t [N_REQ-1:0]      src_sel;
  logic [N_REQ-1:0][DEST_W-1:0] dest_ld;
  logic [N_REQ-1:0]             gnt;
  bus_in_sel_t                  selectOut;
  logic [DEST_W-1:0]            ldOut;
  logic                         busy;

  modport master (
    output req, lock, src_sel, dest_ld,
    input  gnt, selectOut, ldOut, busy
  );

  modport slave (
    input  req, lock, src_sel, dest_ld,
    output gnt, selectOut, ldOut, busy
  );
endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Round-robin picker: first set bit of (req & mask), scanning from ptr and
// wrapping modulo N_REQ. Purely combinational.
module rr_picker #(
  parameter int N_REQ = 3,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  input  logic [N_REQ-1:0] mask,
  output logic             found,
  output logic [IW-1:0]    index
);
  logic [N_REQ-1:0] cand;

  assign cand = req & mask;

  // Walk the ring starting at ptr; the first candidate seen wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && cand[(int'(ptr) + i) % N_REQ]) begin
        found = 1'b1;
        index = IW'((int'(ptr) + i) % N_REQ);
      end
    end
  end
endmodule

// File: rtl/bus_arbiter.sv
// Common-bus arbiter: round-robin ownership with bounded locking. Drives the
// bus multiplexer select and destination load enables for the current owner.
//
// state     | meaning
// ARB_IDLE  | no owner; bus idle, waiting for any request
// ARB_GRANT | owner holds the bus; transfer happens when req[owner] is high
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int DEST_W   = 9,
  parameter int MAX_HOLD = 4
) (
  input logic           clk,
  input logic           rst,
  bus_arbiter_if.slave  bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  arb_state_t       state;
  logic [IW-1:0]    owner;
  logic [IW-1:0]    ptr;
  logic [HW-1:0]    hcnt;

  logic [N_REQ-1:0] own_bit;
  logic             own_req;
  logic             others;
  logic             stay;
  logic [IW-1:0]    next_ptr;
  logic [IW-1:0]    pick_ptr;
  logic [N_REQ-1:0] pick_mask;
  logic             pick_found;
  logic [IW-1:0]    pick_idx;

  assign own_bit  = N_REQ'(1) << owner;
  assign own_req  = bus.req[owner];
  assign others   = |(bus.req & ~own_bit);
  assign stay     = own_req && bus.lock[owner] && (hcnt < HOLD_LAST);
  assign next_ptr = (owner == IW'(N_REQ - 1)) ? '0 : owner + IW'(1);

  // On release the owner is masked out unless it is the only requester,
  // so it may be re-granted back to back only when nobody else waits.
  assign pick_ptr  = (state == ARB_GRANT) ? next_ptr : ptr;
  assign pick_mask = (state == ARB_GRANT && others) ? ~own_bit : '1;

  rr_picker #(.N_REQ(N_REQ), .IW(IW)) u_picker (
    .req   (bus.req),
    .ptr   (pick_ptr),
    .mask  (pick_mask),
    .found (pick_found),
    .index (pick_idx)
  );

  // Ownership FSM: grant, hold under lock up to MAX_HOLD cycles, hand off.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
      owner <= '0;
      ptr   <= '0;
      hcnt  <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            owner <= pick_idx;
            hcnt  <= '0;
            state <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (stay) begin
            hcnt <= hcnt + HW'(1);
          end else begin
            ptr <= next_ptr;
            if (pick_found) begin
              owner <= pick_idx;
              hcnt  <= '0;
            end else begin
              state <= ARB_IDLE;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Bus controls follow the registered owner; only the owner's own
  // request/select/load inputs reach these outputs combinationally.
  always_comb begin
    bus.gnt       = '0;
    bus.selectOut = idle_bus;
    bus.ldOut     = '0;
    if (state == ARB_GRANT) begin
      bus.gnt = own_bit;
      if (own_req) begin
        bus.selectOut = bus.src_sel[owner];
        bus.ldOut     = bus.dest_ld[owner];
      end
    end
  end

  assign bus.busy = (state == ARB_GRANT);
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (N_REQ=3, DEST_W=9, MAX_HOLD=4).
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  bus_arbiter_if #(.N_REQ(3), .DEST_W(9)) bus ();

  bus_arbiter #(.N_REQ(3), .DEST_W(9), .MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Move to just after the next rising edge; inputs are driven here.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    step();
    rst      = 1'b1;
    bus.req  = 3'b000;
    bus.lock = 3'b000;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst         = 1'b1;
    bus.req     = 3'b111;
    bus.lock    = 3'b000;
    bus.src_sel[0] = AC_bus;
    bus.src_sel[1] = DR_bus;
    bus.src_sel[2] = PC_bus;
    bus.dest_ld[0] = 9'h001;
    bus.dest_ld[1] = 9'h002;
    bus.dest_ld[2] = 9'h004;
    for (int i = 0; i < 3; i++) begin
      step();
      #2;
      n_checks++;
      if (bus.gnt !== 3'b000 || bus.selectOut !== idle_bus || bus.ldOut !== 9'h000 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc %0d: gnt=%b sel=%0d ld=%h busy=%b, expected 000/0/000/0",
                 i, bus.gnt, bus.selectOut, bus.ldOut, bus.busy);
      end
    end
    step();
    rst = 1'b0;
    #2;
    n_checks++;
    if (bus.gnt !== 3'b000 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_cycle: gnt=%b busy=%b, expected 000/0", bus.gnt, bus.busy);
    end
    step();
    #2;
    n_checks++;
    if (bus.gnt !== 3'b001 || bus.selectOut !== AC_bus || bus.ldOut !== 9'h001 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_grant: gnt=%b sel=%0d ld=%h busy=%b, expected 001/%0d/001/1",
               bus.gnt, bus.selectOut, bus.ldOut, bus.busy, AC_bus);
    end
  endtask

  task automatic test_single;
    do_reset();
    bus.req        = 3'b001;
    bus.lock       = 3'b000;
    bus.src_sel[0] = AC_bus;
    bus.dest_ld[0] = 9'h002;
    for (int i = 0; i < 5; i++) begin
      step();
      #2;
      n_checks++;
      if (bus.gnt !== 3'b001 || bus.selectOut !== AC_bus || bus.ldOut !== 9'h002 || bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL single cyc %0d: gnt=%b sel=%0d ld=%h busy=%b, expected 001/%0d/002/1",
                 i, bus.gnt, bus.selectOut, bus.ldOut, bus.busy, AC_bus);
      end
    end
  endtask

  task automatic test_round_robin;
    logic [2:0]  eg [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    bus_in_sel_t es [6] = '{AC_bus, DR_bus, PC_bus, AC_bus, DR_bus, PC_bus};
    logic [8:0]  el [6] = '{9'h001, 9'h010, 9'h100, 9'h001, 9'h010, 9'h100};
    do_reset();
    bus.req        = 3'b111;
    bus.lock       = 3'b000;
    bus.src_sel[0] = AC_bus;
    bus.src_sel[1] = DR_bus;
    bus.src_sel[2] = PC_bus;
    bus.dest_ld[0] = 9'h001;
    bus.dest_ld[1] = 9'h010;
    bus.dest_ld[2] = 9'h100;
    for (int i = 0; i < 6; i++) begin
      step();
      #2;
      n_checks++;
      if (bus.gnt !== eg[i] || bus.selectOut !== es[i] || bus.ldOut !== el[i]) begin
        n_fail++;
        $display("FAIL round_robin cyc %0d: gnt=%b sel=%0d ld=%h, expected %b/%0d/%h",
                 i, bus.gnt, bus.selectOut, bus.ldOut, eg[i], es[i], el[i]);
      end
    end
  endtask

  task automatic test_lock_limit;
    logic [2:0] eg [10] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010,
                            3'b001, 3'b001, 3'b001, 3'b001, 3'b010};
    do_reset();
    bus.req  = 3'b011;
    bus.lock = 3'b001;
    for (int i = 0; i < 10; i++) begin
      step();
      #2;
      n_checks++;
      if (bus.gnt !== eg[i] || bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL lock_limit cyc %0d: gnt=%b busy=%b, expected %b/1", i, bus.gnt, bus.busy, eg[i]);
      end
    end
  endtask

  task automatic test_early_drop;
    do_reset();
    bus.req        = 3'b110;
    bus.lock       = 3'b010;
    bus.src_sel[1] = DR_bus;
    bus.src_sel[2] = PC_bus;
    bus.dest_ld[1] = 9'h010;
    bus.dest_ld[2] = 9'h100;
    for (int i = 0; i < 2; i++) begin
      step();
      #2;
      n_checks++;
      if (bus.gnt !== 3'b010 || bus.selectOut !== DR_bus || bus.ldOut !== 9'h010) begin
        n_fail++;
        $display("FAIL drop_locked cyc %0d: gnt=%b sel=%0d ld=%h, expected 010/%0d/010",
                 i, bus.gnt, bus.selectOut, bus.ldOut, DR_bus);
      end
    end
    step();
    bus.req = 3'b100;
    #2;
    n_checks++;
    if (bus.gnt !== 3'b010 || bus.selectOut !== idle_bus || bus.ldOut !== 9'h000 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_cycle: gnt=%b sel=%0d ld=%h busy=%b, expected 010/0/000/1",
               bus.gnt, bus.selectOut, bus.ldOut, bus.busy);
    end
    step();
    bus.req = 3'b000;
    #2;
    n_checks++;
    if (bus.gnt !== 3'b100 || bus.selectOut !== idle_bus || bus.ldOut !== 9'h000) begin
      n_fail++;
      $display("FAIL drop_handoff: gnt=%b sel=%0d ld=%h, expected 100/0/000",
               bus.gnt, bus.selectOut, bus.ldOut);
    end
    step();
    #2;
    n_checks++;
    if (bus.gnt !== 3'b000 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_to_idle: gnt=%b busy=%b, expected 000/0", bus.gnt, bus.busy);
    end
  endtask

  task automatic test_reset_mid_lock;
    do_reset();
    bus.req  = 3'b010;
    bus.lock = 3'b000;
    step();
    bus.req  = 3'b100;
    bus.lock = 3'b100;
    #2;
    n_checks++;
    if (bus.gnt !== 3'b010) begin
      n_fail++;
      $display("FAIL midlock_setup: gnt=%b, expected 010", bus.gnt);
    end
    step();
    #2;
    n_checks++;
    if (bus.gnt !== 3'b100) begin
      n_fail++;
      $display("FAIL midlock_first: gnt=%b, expected 100", bus.gnt);
    end
    step();
    rst = 1'b1;
    #2;
    n_checks++;
    if (bus.gnt !== 3'b100 || bus.ldOut !== bus.dest_ld[2]) begin
      n_fail++;
      $display("FAIL midlock_second: gnt=%b ld=%h, expected 100/%h", bus.gnt, bus.ldOut, 9'h100);
    end
    step();
    rst      = 1'b0;
    bus.req  = 3'b111;
    bus.lock = 3'b000;
    #2;
    n_checks++;
    if (bus.gnt !== 3'b000 || bus.ldOut !== 9'h000 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midlock_reset: gnt=%b ld=%h busy=%b, expected 000/000/0", bus.gnt, bus.ldOut, bus.busy);
    end
    step();
    #2;
    n_checks++;
    if (bus.gnt !== 3'b001) begin
      n_fail++;
      $display("FAIL midlock_restart_ptr: gnt=%b, expected 001", bus.gnt);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_lock_limit();
    test_early_drop();
    test_reset_mid_lock();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
